// File: rtl/widemux_arbiter_if.sv
// Bundle of requester-side, mux-side and consumer-side signals of the wide-mux arbiter.
interface widemux_arbiter_if;
    logic [7:0] req;
    logic [7:0] last;
    logic [7:0] mux_out;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       xfer;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_src;
    logic       out_last;
    logic       out_trunc;
    logic       out_ready;

    modport master (
        input  req, last, mux_out, out_ready,
        output sel, grant, xfer, out_valid, out_data, out_src, out_last, out_trunc
    );

    modport slave (
        output req, last, mux_out, out_ready,
        input  sel, grant, xfer, out_valid, out_data, out_src, out_last, out_trunc
    );
endinterface

// File: rtl/widemux_arbiter.sv
// Round-robin arbiter for the shared 8-input byte mux: holds the grant for a burst and
// registers the selected byte into a valid/ready output stage.
module widemux_arbiter #(
    parameter int unsigned MAX_BEATS = 16
) (
    input logic               clk,
    input logic               reset,
    widemux_arbiter_if.master bus
);
    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [7:0] LastCnt = 8'(MAX_BEATS - 1);

    state_e     state_q, state_d;
    logic [2:0] gidx_q, gidx_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic [2:0] out_src_q, out_src_d;
    logic       out_last_q, out_last_d;
    logic       out_trunc_q, out_trunc_d;

    logic       busy, can_load, xfer, beat_end, rel;
    logic [7:0] gmask, others;

    // First set bit of mask scanning upward from start with mod-8 wrap.
    function automatic logic [2:0] pick(input logic [7:0] mask, input logic [2:0] start);
        logic [2:0] res;
        logic [2:0] idx;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        busy     = (state_q == StBusy);
        gmask    = 8'b1 << gidx_q;
        can_load = !out_valid_q || bus.out_ready;
        xfer     = busy && bus.req[gidx_q] && can_load;
        beat_end = bus.last[gidx_q] || (beat_cnt_q == LastCnt);
        // A drop (req withdrawn) releases without moving a beat.
        rel      = busy && (!bus.req[gidx_q] || (xfer && beat_end));
        others   = bus.req & ~gmask;
    end

    always_comb begin
        state_d    = state_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    gidx_d     = pick(bus.req, ptr_q);
                    beat_cnt_d = '0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
                if (rel) begin
                    ptr_d      = gidx_q + 3'd1;
                    beat_cnt_d = '0;
                    // Others first; otherwise a still-requesting owner starts a new burst.
                    if (|others) begin
                        gidx_d = pick(others, gidx_q + 3'd1);
                    end else if (!bus.req[gidx_q]) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        out_trunc_d = out_trunc_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.mux_out;
            out_src_d   = gidx_q;
            out_last_d  = beat_end;
            out_trunc_d = beat_end && !bus.last[gidx_q];
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            gidx_q      <= '0;
            ptr_q       <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    assign bus.grant     = busy ? gmask : 8'h00;
    assign bus.sel       = busy ? gidx_q : 3'd0;
    assign bus.xfer      = xfer;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_trunc = out_trunc_q;
endmodule

// File: tb/tb_widemux_arbiter.sv
// Bench for widemux_arbiter: scripted requesters feed per-source expected byte queues whose
// last/trunc flags come from burst length and the beat limit.
module tb_widemux_arbiter;
    localparam int unsigned MaxBeats = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    widemux_arbiter_if bus ();

    widemux_arbiter #(.MAX_BEATS(MaxBeats)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] req_v, last_v;
    logic [7:0] mux_byte [8];
    logic       ready_v;

    assign bus.req       = req_v;
    assign bus.last      = last_v;
    assign bus.mux_out   = mux_byte[bus.sel];
    assign bus.out_ready = ready_v;

    logic [7:0] sbyte_q [8][$];
    bit         slast_q [8][$];
    logic [9:0] exp_q   [8][$];  // {data, last, trunc}
    bit         presenting [8];
    int         xfer_cnt [8];
    int         acc_log [$];
    int         out_log [$];
    int         ready_plan [$];
    bit         rand_ready, rand_gaps;
    int         n_checks, n_pass, n_fail;

    logic [7:0] s_grant, s_data;
    logic [2:0] s_sel, s_src;
    logic       s_xfer, s_ov, s_last, s_trunc;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit, want finished");
        $fatal(1);
    end

    task automatic add_burst(input int i, input int len, input bit has_last,
                             input logic [7:0] b0);
        logic [7:0] b;
        bit         fin, tr;
        for (int k = 1; k <= len; k++) begin
            b   = b0 + 8'(k - 1);
            fin = has_last && (k == len);
            tr  = !fin && ((k % int'(MaxBeats)) == 0);
            sbyte_q[i].push_back(b);
            slast_q[i].push_back(fin);
            exp_q[i].push_back({b, fin || tr, tr});
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 8; i++) begin
            if (!presenting[i] && sbyte_q[i].size() > 0)
                presenting[i] = !rand_gaps || ($urandom_range(0, 2) != 0);
            req_v[i]    = presenting[i];
            last_v[i]   = presenting[i] ? slast_q[i][0] : 1'b0;
            mux_byte[i] = presenting[i] ? sbyte_q[i][0] : 8'h00;
        end
        if (ready_plan.size() > 0) ready_v = (ready_plan.pop_front() != 0);
        else ready_v = !rand_ready || ($urandom_range(0, 3) != 0);
    endtask

    // One clock cycle: drive, sample at negedge, retire accepted beats after the edge.
    task automatic step();
        int         acc;
        logic [9:0] e;
        bit         fin;
        drive();
        @(negedge clk);
        s_grant = bus.grant;   s_sel = bus.sel;         s_xfer = bus.xfer;
        s_ov    = bus.out_valid; s_data = bus.out_data; s_src = bus.out_src;
        s_last  = bus.out_last;  s_trunc = bus.out_trunc;
        acc = -1;
        if (bus.xfer) begin
            acc = int'(bus.sel);
            n_checks++;
            if (bus.grant !== (8'b1 << bus.sel) || req_v[bus.sel] !== 1'b1) begin
                n_fail++;
                $display("FAIL xfer_protocol: grant=%h sel=%0d req=%h, want one-hot grant on a requester",
                         bus.grant, bus.sel, req_v);
            end else n_pass++;
        end
        if (bus.out_valid && ready_v) begin
            n_checks++;
            if (exp_q[bus.out_src].size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: src=%0d data=%h, want no byte",
                         bus.out_src, bus.out_data);
            end else begin
                e = exp_q[bus.out_src].pop_front();
                if ({bus.out_data, bus.out_last, bus.out_trunc} !== e) begin
                    n_fail++;
                    $display("FAIL out_byte src %0d: got data=%h last=%b trunc=%b, want %h %b %b",
                             bus.out_src, bus.out_data, bus.out_last, bus.out_trunc,
                             e[9:2], e[1], e[0]);
                end else n_pass++;
            end
            out_log.push_back(int'(bus.out_src));
        end
        @(posedge clk);
        #1;
        if (acc >= 0 && sbyte_q[acc].size() > 0) begin
            xfer_cnt[acc]++;
            acc_log.push_back(acc);
            void'(sbyte_q[acc].pop_front());
            fin = slast_q[acc].pop_front();
            if (fin || sbyte_q[acc].size() == 0) presenting[acc] = 1'b0;
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < 8; i++)
            if (sbyte_q[i].size() > 0 || exp_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (pending()) begin
            n_fail++;
            $display("FAIL %s_drain: traffic pending after %0d cycles, want drained", name, budget);
        end else n_pass++;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req_v   = '0;
        last_v  = '0;
        ready_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mux_byte[i] = 8'h00;
            sbyte_q[i].delete();
            slast_q[i].delete();
            exp_q[i].delete();
            presenting[i] = 1'b0;
            xfer_cnt[i]   = 0;
        end
        acc_log.delete();
        out_log.delete();
        ready_plan.delete();
        rand_ready = 1'b0;
        rand_gaps  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.grant, bus.sel, bus.xfer, bus.out_valid, bus.out_data, bus.out_src,
             bus.out_last, bus.out_trunc} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%h sel=%0d xfer=%b ov=%b data=%h, want all zero",
                     bus.grant, bus.sel, bus.xfer, bus.out_valid, bus.out_data);
        end else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_beat();
        do_reset();
        add_burst(2, 1, 1'b1, 8'hA5);
        step();
        n_checks++;
        if (s_grant !== 8'h00) begin
            n_fail++; $display("FAIL single_idle_grant: got %h, want 00", s_grant);
        end else n_pass++;
        step();
        n_checks++;
        if ({s_grant, s_sel, s_xfer} !== {8'h04, 3'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grant: grant=%h sel=%0d xfer=%b, want 04 2 1",
                     s_grant, s_sel, s_xfer);
        end else n_pass++;
        step();
        n_checks++;
        if ({s_ov, s_data, s_src, s_last, s_trunc} !== {1'b1, 8'hA5, 3'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_out: ov=%b data=%h src=%0d last=%b trunc=%b, want 1 a5 2 1 0",
                     s_ov, s_data, s_src, s_last, s_trunc);
        end else n_pass++;
        repeat (2) step();
        n_checks++;
        if (s_grant !== 8'h00) begin
            n_fail++; $display("FAIL single_back_idle: grant=%h, want 00", s_grant);
        end else n_pass++;
        // Pointer now 3: requesters 1 and 4 together must go to 4 first.
        acc_log.delete();
        add_burst(1, 1, 1'b1, 8'h11);
        add_burst(4, 1, 1'b1, 8'h44);
        drain("single_ptr", 20);
        n_checks++;
        if (acc_log.size() == 0 || acc_log[0] != 4) begin
            n_fail++;
            $display("FAIL single_ptr: first source %0d, want 4",
                     acc_log.size() > 0 ? acc_log[0] : -1);
        end else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] g [4];
        int         want_src [4];
        logic [7:0] want_g [4];
        want_src = '{0, 7, 0, 7};
        want_g   = '{8'h01, 8'h80, 8'h01, 8'h80};
        do_reset();
        add_burst(0, 1, 1'b1, 8'h10);
        add_burst(0, 1, 1'b1, 8'h20);
        add_burst(7, 1, 1'b1, 8'h70);
        add_burst(7, 1, 1'b1, 8'h80);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            g[k] = s_grant;
        end
        drain("rr", 20);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (g[k] !== want_g[k]) begin
                n_fail++; $display("FAIL rr_grant %0d: got %h, want %h", k, g[k], want_g[k]);
            end else n_pass++;
            n_checks++;
            if (out_log.size() <= k || out_log[k] != want_src[k]) begin
                n_fail++;
                $display("FAIL rr_src %0d: got %0d, want %0d", k,
                         out_log.size() > k ? out_log[k] : -1, want_src[k]);
            end else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        add_burst(5, 3, 1'b1, 8'hB0);
        ready_plan = '{1, 1, 0, 0, 0, 0};
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (s_xfer !== 1'b0 || s_grant !== 8'h20) begin
                n_fail++;
                $display("FAIL bp_stall %0d: xfer=%b grant=%h, want 0 20", k, s_xfer, s_grant);
            end else n_pass++;
        end
        drain("bp", 30);
        n_checks++;
        if (xfer_cnt[5] != 3 || out_log.size() != 3) begin
            n_fail++;
            $display("FAIL bp_count: xfers=%0d outs=%0d, want 3 3", xfer_cnt[5], out_log.size());
        end else n_pass++;
    endtask

    task automatic test_truncation();
        int n;
        int want [7];
        want = '{1, 1, 1, 1, 3, 1, 1};
        do_reset();
        add_burst(1, 6, 1'b0, 8'h30);
        add_burst(3, 1, 1'b1, 8'h60);
        n = 0;
        while (xfer_cnt[1] < 4 && n < 20) begin
            step();
            n++;
        end
        step();
        n_checks++;
        if (s_grant !== 8'h08) begin
            n_fail++; $display("FAIL trunc_handover: grant=%h, want 08", s_grant);
        end else n_pass++;
        drain("trunc", 30);
        n_checks++;
        if (acc_log.size() != 7) begin
            n_fail++; $display("FAIL trunc_beats: got %0d beats, want 7", acc_log.size());
        end else begin
            n_pass++;
            for (int k = 0; k < 7; k++) begin
                n_checks++;
                if (acc_log[k] != want[k]) begin
                    n_fail++;
                    $display("FAIL trunc_order %0d: src %0d, want %0d", k, acc_log[k], want[k]);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_drop();
        int n;
        do_reset();
        add_burst(6, 5, 1'b1, 8'hC0);
        repeat (3) void'(exp_q[6].pop_back());
        n = 0;
        while (xfer_cnt[6] < 2 && n < 20) begin
            step();
            n++;
        end
        sbyte_q[6].delete();
        slast_q[6].delete();
        presenting[6] = 1'b0;
        step();
        n_checks++;
        if (s_xfer !== 1'b0) begin
            n_fail++; $display("FAIL drop_no_xfer: xfer=%b, want 0", s_xfer);
        end else n_pass++;
        step();
        n_checks++;
        if (s_grant !== 8'h00 || xfer_cnt[6] != 2) begin
            n_fail++;
            $display("FAIL drop_idle: grant=%h xfers=%0d, want 00 2", s_grant, xfer_cnt[6]);
        end else n_pass++;
        drain("drop", 10);
        // Pointer now 7: requesters 0 and 7 together must go to 7 first.
        acc_log.delete();
        add_burst(0, 1, 1'b1, 8'h01);
        add_burst(7, 1, 1'b1, 8'h07);
        drain("drop_ptr", 20);
        n_checks++;
        if (acc_log.size() == 0 || acc_log[0] != 7) begin
            n_fail++;
            $display("FAIL drop_ptr: first source %0d, want 7",
                     acc_log.size() > 0 ? acc_log[0] : -1);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_burst(3, 6, 1'b1, 8'hD0);
        ready_plan = '{1, 1, 0, 0};
        repeat (3) step();
        n_checks++;
        if (s_ov !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pre: out_valid=%b, want 1", s_ov);
        end else n_pass++;
        ready_v = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.grant, bus.sel, bus.xfer, bus.out_valid, bus.out_data, bus.out_src,
             bus.out_last, bus.out_trunc} !== 26'd0) begin
            n_fail++;
            $display("FAIL midreset_state: grant=%h sel=%0d xfer=%b ov=%b data=%h, want all zero",
                     bus.grant, bus.sel, bus.xfer, bus.out_valid, bus.out_data);
        end else n_pass++;
        do_reset();
    endtask

    task automatic test_random();
        int total, got;
        do_reset();
        rand_ready = 1'b1;
        rand_gaps  = 1'b1;
        total = 0;
        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < 3; b++) begin
                int len;
                len = int'($urandom_range(1, 9));
                add_burst(i, len, 1'b1, 8'($urandom));
                total += len;
            end
        end
        drain("random", 3000);
        got = 0;
        for (int i = 0; i < 8; i++) got += xfer_cnt[i];
        n_checks++;
        if (got != total) begin
            n_fail++; $display("FAIL random_beats: got %0d beats, want %0d", got, total);
        end else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
